// File: rtl/switch_tx_arbiter.sv
// switch_tx_arbiter: round-robin owner of the shared broadcast tx path.
// Enforces inter-frame gap, grant-response timeout and max frame length.
module switch_tx_arbiter #(
  parameter int N       = 3,
  parameter int IFG     = 10,
  parameter int WAIT    = 16,
  parameter int MAX_LEN = 1522
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  input  logic [N*8-1:0]       din,
  input  logic [N-1:0]         vin,
  output logic [N*8-1:0]       dout,
  output logic [N-1:0]         vout,
  output logic [$clog2(N)-1:0] src,
  output logic                 busy,
  output logic                 err_timeout,
  output logic                 err_oversize
);

  localparam int SW = $clog2(N);
  localparam int WW = $clog2(WAIT + 1);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int GW = $clog2(IFG + 1);

  typedef enum logic [2:0] {
    IDLE, GRANT, XFER, DRAIN, GAP
  } state_t;

  state_t        state;
  logic [SW-1:0] last;
  logic [SW-1:0] pick;
  logic          found;
  logic [N-1:0]  pick_oh;
  logic [N-1:0]  src_oh;
  logic [7:0]    sel_d;
  logic          sel_v;
  logic          sel_r;
  logic [WW-1:0] wcnt;
  logic [LW-1:0] len;
  logic [GW-1:0] gcnt;
  int            c;

  assign busy = (state != IDLE);

  // Round-robin pick: first requester after the last granted port.
  always_comb begin
    pick  = last;
    found = 1'b0;
    c     = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last) + i) % N;
      if (!found && req[c[SW-1:0]]) begin
        found = 1'b1;
        pick  = c[SW-1:0];
      end
    end
  end

  // One-hot decodes and source-port byte/valid/request mux.
  always_comb begin
    sel_d   = '0;
    src_oh  = '0;
    pick_oh = '0;
    for (int i = 0; i < N; i++) begin
      src_oh[i]  = (SW'(i) == src);
      pick_oh[i] = (SW'(i) == pick);
      if (SW'(i) == src)
        sel_d = din[i*8 +: 8];
    end
  end

  assign sel_v = |(vin & src_oh);
  assign sel_r = |(req & src_oh);

  // Scheduler FSM with registered grant, data and error pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      last         <= SW'(N - 1);
      src          <= '0;
      gnt          <= '0;
      dout         <= '0;
      vout         <= '0;
      wcnt         <= '0;
      len          <= '0;
      gcnt         <= '0;
      err_timeout  <= 1'b0;
      err_oversize <= 1'b0;
    end else begin
      vout         <= '0;
      err_timeout  <= 1'b0;
      err_oversize <= 1'b0;
      unique case (state)
        IDLE: begin
          if (found) begin
            src   <= pick;
            last  <= pick;
            gnt   <= pick_oh;
            wcnt  <= '0;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (sel_v) begin
            dout  <= {N{sel_d}};
            vout  <= ~src_oh;
            len   <= LW'(1);
            state <= XFER;
          end else if (!sel_r) begin
            gnt   <= '0;
            state <= IDLE;
          end else if (wcnt == WW'(WAIT - 1)) begin
            err_timeout <= 1'b1;
            gnt         <= '0;
            state       <= IDLE;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        XFER: begin
          if (!sel_v) begin
            gnt   <= '0;
            gcnt  <= '0;
            state <= GAP;
          end else if (len == LW'(MAX_LEN)) begin
            err_oversize <= 1'b1;
            gnt          <= '0;
            state        <= DRAIN;
          end else begin
            dout <= {N{sel_d}};
            vout <= ~src_oh;
            len  <= len + 1'b1;
          end
        end
        DRAIN: begin
          if (!sel_v) begin
            gcnt  <= '0;
            state <= GAP;
          end
        end
        GAP: begin
          if (gcnt == GW'(IFG - 1))
            state <= IDLE;
          else
            gcnt <= gcnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
